indirect_mat_acc: RTL
=====================

// Module: indirect_mat_acc
// PURPOSE
//  Downstream of the indirect (feature-match) coefficient stage. Per valid sample it forms the
//  Gauss-Newton terms H += Ax^T*Ax + Ay^T*Ay and b += Ax*diffs_x + Ay*diffs_y. It accumulates them
//  over one frame and presents the 21-entry upper-triangular H, the 6-entry b and the sample count
//  to the pose solver at frame end.
// PARAMETERS
//  MAT_ACC_BW   64   signed accumulator width for H and b entries (saturating)
//  CNT_BW       20   valid-sample counter width (saturating)
// PORTS
//  i_clk          in   1                    clock
//  i_rst_n        in   1                    reset, asynchronous, active-low
//  i_frame_start  in   1                    first-sample marker, qualified independently of i_valid
//  i_frame_end    in   1                    last-sample marker, qualified independently of i_valid
//  i_valid        in   1                    sample valid
//  i_Ax           in   6 x ID_COE_BW        signed x-row Jacobian coefficients 0..5
//  i_Ay           in   6 x ID_COE_BW        signed y-row Jacobian coefficients 0..5
//  i_diffs_x      in   H_SIZE_BW+1          signed x residual
//  i_diffs_y      in   V_SIZE_BW+1          signed y residual
//  o_done         out  1                    one-cycle pulse; o_mat/o_vec/o_count are valid from this cycle
//  o_mat          out  21 x MAT_ACC_BW      H upper triangle, row-major: k0=(0,0),k1=(0,1)..k5=(0,5),k6=(1,1)..k20=(5,5)
//  o_vec          out  6 x MAT_ACC_BW       b
//  o_count        out  CNT_BW               number of valid samples in the frame
// BEHAVIOUR
//  - Reset: all accumulators, output registers, o_count and o_done are 0. FSM goes to IDLE.
//  - Pipeline S1 (registered): 21 products Ax_i*Ax_j+Ay_i*Ay_j (i<=j) and 6 products Ax_i*dx+Ay_i*dy.
//    Each is full precision, 2*ID_COE_BW+1 and ID_COE_BW+max(H,V)_SIZE_BW+2 bits, sign-extended.
//    valid, start and end travel alongside as flags.
//    S2: accumulate. If S1 start=1, acc <= (valid ? product : 0); else if valid, acc <= sat(acc + product).
//  - Saturation: on overflow, clamp to the signed max or min of MAT_ACC_BW. The entry then holds the
//    clamped value until the next frame start. o_count saturates at all-ones.
//  - FSM: IDLE -> ACC on S1 start. In ACC, S1 end -> FLUSH. FLUSH (1 cycle) latches the accumulators
//    into the output registers, pulses o_done, then goes to IDLE.
//    Latency: o_done is high exactly 3 cycles after the i_frame_end sample cycle.
//  - A sample with i_valid=1 on the same cycle as i_frame_start or i_frame_end is included.
//    start and end on the same cycle form a one-sample frame.
//  - Samples with i_valid=0 change nothing. Valid samples seen in IDLE (no start yet) are dropped.
//  - Start while in ACC (missing end) restarts accumulation; no o_done is issued for the aborted frame.
//  - End seen in IDLE is ignored; no o_done.
//  - Start arriving 1 cycle after end: the new frame's clear does not disturb the FLUSH latch. Outputs
//    come from the accumulators as they stood before the clear, because FLUSH samples the S2 registers
//    on the same edge that the new start's S1 flag reaches S2.
//  - Outputs hold their values until the next o_done. Reset mid-frame zeroes everything; no o_done.
// STRUCTURE
//  - RgbdVoConfigPk additions: MAT_ACC_BW, MAT_NUM=21, VEC_NUM=6, CNT_BW, and a constant table
//    MAT_IDX_I/MAT_IDX_J[21] mapping k to (i,j). Add the FSM enum {IDLE,ACC,FLUSH} there as well.
//  - Sub-module MatAccCell: one S1 dual-product sum plus S2 saturating accumulator, with product width
//    as a parameter. It is instantiated 21+6 times through generate loops using the index table.
//    The top-level block holds only the FSM, counter and output latch.
// TESTING
//  1 Single sample: start=end=valid=1, Ax=[1,2,3,4,5,6], Ay=0, dx=2, dy=0
//    -> o_done 3 cycles later; mat k0=1, k5=6, k20=36; vec=[2,4,6,8,10,12]; count=1.
//  2 Four-sample frame with Ax=[1,0,0,0,0,0], Ay=[0,1,0,0,0,0], dx=3, dy=-5, plus two i_valid=0 gaps
//    -> k0=4, k6=4, others 0; vec=[12,-20,0,0,0,0]; count=4.
//  3 Back-to-back frames, start 1 cycle after end, different data
//    -> two o_done pulses; each result matches its own frame; the first result is unchanged by the
//       second frame's clear.
//  4 Saturation: MAT_ACC_BW=16, 300 samples of Ax0=-128, Ay=0, dx=+127
//    -> vec0 = -32768 and stays there; k0 = 32767.
//  5 Protocol errors: end with no start -> no o_done.
//    Second start mid-frame -> only post-restart samples counted.
//    Samples before the first start -> dropped.
//  6 i_rst_n low mid-frame for 1 cycle -> all outputs 0 immediately (asynchronous); no o_done;
//    the next full frame accumulates correctly.

Source files
------------

// File: rtl/indirect_mat_acc_pkg.sv
// Shared widths, the H upper-triangle index table and the frame FSM states for
// the indirect Gauss-Newton accumulator.
package indirect_mat_acc_pkg;

    localparam int ID_COE_BW      = 16;
    localparam int H_SIZE_BW      = 11;
    localparam int V_SIZE_BW      = 10;
    localparam int MAT_ACC_BW_DEF = 64;
    localparam int CNT_BW_DEF     = 20;
    localparam int MAT_NUM        = 21;
    localparam int VEC_NUM        = 6;

    // k -> (i,j) for the row-major upper triangle of the 6x6 H matrix
    localparam int MAT_IDX_I [MAT_NUM] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1,
                                           2, 2, 2, 2, 3, 3, 3, 4, 4, 5};
    localparam int MAT_IDX_J [MAT_NUM] = '{0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5,
                                           2, 3, 4, 5, 3, 4, 5, 4, 5, 5};

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FLUSH
    } acc_state_e;

endpackage

// File: rtl/indirect_mat_acc_cell.sv
// One accumulator entry: registered dual product a0*b0 + a1*b1, then a sticky
// saturating accumulator that restarts on the frame-start flag.
module indirect_mat_acc_cell #(
    parameter int COEF_W = 16,
    parameter int DATA_W = 16,
    parameter int PROD_W = COEF_W + DATA_W + 1,
    parameter int ACC_W  = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     vld_p1,
    input  logic                     start_p1,
    input  logic signed [COEF_W-1:0] a0,
    input  logic signed [COEF_W-1:0] a1,
    input  logic signed [DATA_W-1:0] b0,
    input  logic signed [DATA_W-1:0] b1,
    output logic signed [ACC_W-1:0]  acc_p2
);

    localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] s);
        if (s > ACC_MAX)      sat_acc = ACC_MAX[ACC_W-1:0];
        else if (s < ACC_MIN) sat_acc = ACC_MIN[ACC_W-1:0];
        else                  sat_acc = s[ACC_W-1:0];
    endfunction

    function automatic logic is_ovf(input logic signed [SUM_W-1:0] s);
        is_ovf = (s > ACC_MAX) || (s < ACC_MIN);
    endfunction

    logic signed [PROD_W-1:0] prod_p1;
    logic signed [SUM_W-1:0]  base_p1;
    logic signed [SUM_W-1:0]  addend_p1;
    logic signed [SUM_W-1:0]  sum_p1;
    logic                     sat_p2;

    // S1: full-precision product pair
    always_ff @(posedge i_clk) begin
        prod_p1 <= PROD_W'(a0) * PROD_W'(b0) + PROD_W'(a1) * PROD_W'(b1);
    end

    always_comb begin
        base_p1   = start_p1 ? {SUM_W{1'b0}} : SUM_W'(acc_p2);
        addend_p1 = vld_p1 ? SUM_W'(prod_p1) : {SUM_W{1'b0}};
        sum_p1    = base_p1 + addend_p1;
    end

    // S2: once clamped the entry freezes until the next start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_p2 <= '0;
            sat_p2 <= 1'b0;
        end else if (start_p1 || (vld_p1 && !sat_p2)) begin
            acc_p2 <= sat_acc(sum_p1);
            sat_p2 <= is_ovf(sum_p1);
        end
    end

endmodule

// File: rtl/indirect_mat_acc.sv
// Frame accumulator of Gauss-Newton H (upper triangle) and b terms; holds the
// frame FSM, sample counter and output latch around 27 accumulator cells.
module indirect_mat_acc
    import indirect_mat_acc_pkg::*;
#(
    parameter int MAT_ACC_BW = MAT_ACC_BW_DEF,
    parameter int CNT_BW     = CNT_BW_DEF
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_frame_start,
    input  logic                                  i_frame_end,
    input  logic                                  i_valid,
    input  logic [VEC_NUM-1:0][ID_COE_BW-1:0]     i_Ax,
    input  logic [VEC_NUM-1:0][ID_COE_BW-1:0]     i_Ay,
    input  logic [H_SIZE_BW:0]                    i_diffs_x,
    input  logic [V_SIZE_BW:0]                    i_diffs_y,
    output logic                                  o_done,
    output logic [MAT_NUM-1:0][MAT_ACC_BW-1:0]    o_mat,
    output logic [VEC_NUM-1:0][MAT_ACC_BW-1:0]    o_vec,
    output logic [CNT_BW-1:0]                     o_count
);

    localparam int RES_BW = ((H_SIZE_BW > V_SIZE_BW) ? H_SIZE_BW : V_SIZE_BW) + 1;
    localparam logic [CNT_BW-1:0] CNT_MAX = '1;

    logic                                vld_p1, start_p1, end_p1;
    logic [CNT_BW-1:0]                   cnt_p2;
    logic [MAT_NUM-1:0][MAT_ACC_BW-1:0]  mat_acc;
    logic [VEC_NUM-1:0][MAT_ACC_BW-1:0]  vec_acc;
    logic signed [RES_BW-1:0]            dx_ext, dy_ext;
    acc_state_e                          state, state_nxt;

    assign dx_ext = RES_BW'($signed(i_diffs_x));
    assign dy_ext = RES_BW'($signed(i_diffs_y));

    // S1: control flags travel with the registered products
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1   <= 1'b0;
            start_p1 <= 1'b0;
            end_p1   <= 1'b0;
        end else begin
            vld_p1   <= i_valid;
            start_p1 <= i_frame_start;
            end_p1   <= i_frame_end;
        end
    end

    for (genvar k = 0; k < MAT_NUM; k++) begin : g_mat
        indirect_mat_acc_cell #(
            .COEF_W (ID_COE_BW),
            .DATA_W (ID_COE_BW),
            .ACC_W  (MAT_ACC_BW)
        ) u_cell (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .vld_p1   (vld_p1),
            .start_p1 (start_p1),
            .a0       (i_Ax[MAT_IDX_I[k]]),
            .a1       (i_Ay[MAT_IDX_I[k]]),
            .b0       (i_Ax[MAT_IDX_J[k]]),
            .b1       (i_Ay[MAT_IDX_J[k]]),
            .acc_p2   (mat_acc[k])
        );
    end

    for (genvar v = 0; v < VEC_NUM; v++) begin : g_vec
        indirect_mat_acc_cell #(
            .COEF_W (ID_COE_BW),
            .DATA_W (RES_BW),
            .ACC_W  (MAT_ACC_BW)
        ) u_cell (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .vld_p1   (vld_p1),
            .start_p1 (start_p1),
            .a0       (i_Ax[v]),
            .a1       (i_Ay[v]),
            .b0       (dx_ext),
            .b1       (dy_ext),
            .acc_p2   (vec_acc[v])
        );
    end

    // S2: sample counter follows the same restart rule as the accumulators
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                         cnt_p2 <= '0;
        else if (start_p1)                    cnt_p2 <= CNT_BW'(vld_p1);
        else if (vld_p1 && cnt_p2 != CNT_MAX) cnt_p2 <= cnt_p2 + CNT_BW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A start seen during FLUSH opens the next frame directly
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_p1) state_nxt = end_p1 ? FLUSH : ACC;
            ACC:     if (end_p1)   state_nxt = FLUSH;
            FLUSH:   state_nxt = start_p1 ? (end_p1 ? FLUSH : ACC) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output latch samples S2 on the edge that leaves FLUSH
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_done  <= 1'b0;
            o_mat   <= '0;
            o_vec   <= '0;
            o_count <= '0;
        end else begin
            o_done <= (state == FLUSH);
            if (state == FLUSH) begin
                o_mat   <= mat_acc;
                o_vec   <= vec_acc;
                o_count <= cnt_p2;
            end
        end
    end

endmodule
